// File: rtl/microwave_ctrl_pkg.sv
// microwave_ctrl_pkg: shared state encoding for the microwave sequencer and its bench
package microwave_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_SET   = 3'd2,
        ST_COOK  = 3'd3,
        ST_PAUSE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/microwave_ctrl_tick_prescaler.sv
// tick_prescaler: divides clk down to the timer decrement rate, holding its count while not running
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic clear_n,
    input  logic i_run,
    input  logic i_clear,
    output logic o_tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] r_cnt;

    assign o_tick = (r_cnt == LAST);

    // count 0..TICK_DIV-1 while running; the terminal count marks the tick and wraps
    always_ff @(posedge clk) begin
        if (!clear_n || i_clear)
            r_cnt <= '0;
        else if (i_run)
            r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/microwave_ctrl.sv
// microwave_ctrl: sequences keypad, start/stop and door inputs into timer, magnetron and beep controls
module microwave_ctrl
    import microwave_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int BEEP_TICKS = 3
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic [3:0] timer_data,
    output logic       timer_load,
    output logic       timer_enable,
    output logic       timer_clear,
    output logic       mag_on,
    output logic       beep,
    output logic [2:0] state
);

    localparam int BW = $clog2(BEEP_TICKS + 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);

    state_t          r_state;
    state_t          w_next;
    logic            r_key_prev, r_start_prev, r_stop_prev;
    logic [3:0]      r_data;
    logic            r_load, r_enable, r_clear, r_mag, r_beep;
    logic [BW-1:0]   r_beep_cnt;
    logic [3:0]      w_data;
    logic            w_load, w_enable, w_clear;
    logic            w_key_evt, w_start_evt, w_stop_evt;
    logic            w_tick, w_psc_run, w_psc_clear;

    assign w_key_evt   = key_valid & ~r_key_prev;
    assign w_start_evt = start & ~r_start_prev;
    assign w_stop_evt  = stop & ~r_stop_prev;

    assign timer_data   = r_data;
    assign timer_load   = r_load;
    assign timer_enable = r_enable;
    assign timer_clear  = r_clear;
    assign mag_on       = r_mag;
    assign beep         = r_beep;
    assign state        = r_state;

    // the prescaler freezes on the cycle cooking is interrupted so a resume continues the same second;
    // it restarts from zero on entry to COOK from SET and on entry to DONE
    assign w_psc_run   = (r_state == ST_DONE) || (r_state == ST_COOK && w_next == ST_COOK);
    assign w_psc_clear = !(r_state inside {ST_COOK, ST_PAUSE, ST_DONE}) ||
                         (r_state == ST_COOK && w_next == ST_DONE);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .clear_n (clear_n),
        .i_run   (w_psc_run),
        .i_clear (w_psc_clear),
        .o_tick  (w_tick)
    );

    // next state and the single timer command for this cycle; event priority is encoded by branch order
    always_comb begin
        w_next   = r_state;
        w_data   = r_data;
        w_load   = 1'b0;
        w_enable = 1'b0;
        w_clear  = 1'b0;
        unique case (r_state)
            ST_INIT: begin
                w_clear = 1'b1;
                w_next  = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_key_evt) begin
                    w_load = 1'b1;
                    w_data = key_code;
                    w_next = ST_SET;
                end
            end
            ST_SET: begin
                if (w_stop_evt) begin
                    w_clear = 1'b1;
                    w_next  = ST_IDLE;
                end else if (w_start_evt) begin
                    if (door_closed && !timer_zero)
                        w_next = ST_COOK;
                end else if (w_key_evt) begin
                    w_load = 1'b1;
                    w_data = key_code;
                end
            end
            ST_COOK: begin
                if (timer_zero)
                    w_next = ST_DONE;
                else if (!door_closed || w_stop_evt)
                    w_next = ST_PAUSE;
                else
                    w_enable = w_tick;
            end
            ST_PAUSE: begin
                if (w_stop_evt) begin
                    w_clear = 1'b1;
                    w_next  = ST_IDLE;
                end else if (w_start_evt && door_closed) begin
                    w_next = ST_COOK;
                end
            end
            ST_DONE: begin
                if (w_stop_evt || !door_closed || (w_tick && r_beep_cnt == BEEP_LAST))
                    w_next = ST_IDLE;
            end
            default: w_next = ST_INIT;
        endcase
    end

    // register state, outputs and button history so every output is glitch-free
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            r_state      <= ST_INIT;
            r_data       <= '0;
            r_load       <= 1'b0;
            r_enable     <= 1'b0;
            r_clear      <= 1'b0;
            r_mag        <= 1'b0;
            r_beep       <= 1'b0;
            r_key_prev   <= 1'b0;
            r_start_prev <= 1'b0;
            r_stop_prev  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_data       <= w_data;
            r_load       <= w_load;
            r_enable     <= w_enable;
            r_clear      <= w_clear;
            r_mag        <= (w_next == ST_COOK);
            r_beep       <= (w_next == ST_DONE);
            r_key_prev   <= key_valid;
            r_start_prev <= start;
            r_stop_prev  <= stop;
        end
    end

    // count elapsed ticks of the end-of-cook beep; idle at zero outside DONE
    always_ff @(posedge clk) begin
        if (!clear_n || r_state != ST_DONE)
            r_beep_cnt <= '0;
        else if (w_tick)
            r_beep_cnt <= r_beep_cnt + 1'b1;
    end

endmodule
